fifo_param: RTL and testbench

Parametrised synchronous FIFO, the successor to the fixed 8-bit FIFO. Generalises data width and depth and adds programmable almost-full/almost-empty flags, a synchronous flush, defined push-and-pop-when-full behaviour, and sticky overflow/underflow error flags. It sits between any producer/consumer pair in one clock domain and keeps the `buf_in`/`buf_out`/`wr_en`/`rd_en`/`buf_empty`/`buf_full`/`fifo_counter` port contract.

---
 rtl/fifo_param_if.sv | 32 +++
 rtl/fifo_param.sv | 105 ++++++++++
 tb/tb_fifo_param.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// rtl/fifo_param_if.sv - handshake and status bundle for fifo_param
interface fifo_param_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  flush;
   logic [DATA_WIDTH-1:0] buf_in;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] buf_out;
   logic                  buf_empty;
   logic                  buf_full;
   logic                  almost_empty;
   logic                  almost_full;
   logic [CNT_W-1:0]      fifo_counter;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, buf_in, wr_en, rd_en,
      input  buf_out, buf_empty, buf_full, almost_empty, almost_full,
             fifo_counter, overflow, underflow
   );

   modport slave (
      input  flush, buf_in, wr_en, rd_en,
      output buf_out, buf_empty, buf_full, almost_empty, almost_full,
             fifo_counter, overflow, underflow
   );
endinterface

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with flush and sticky error flags
module fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AFULL_LVL  = DEPTH - 2,
   parameter int AEMPTY_LVL = 2
) (
   input  logic          clk,
   input  logic          rst,
   fifo_param_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
   localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_ovf;
   logic                  r_unf;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_ovf_evt;
   logic w_unf_evt;

   // Accept decisions use the pre-edge count; a pop frees the slot a same-cycle push on full needs.
   always_comb begin
      w_empty   = (r_count == '0);
      w_full    = (r_count == DEPTH_C);
      w_pop     = !bus.flush && bus.rd_en && !w_empty;
      w_push    = !bus.flush && bus.wr_en && (!w_full || w_pop);
      w_ovf_evt = !bus.flush && bus.wr_en && !w_push;
      w_unf_evt = !bus.flush && bus.rd_en && !w_pop;
   end

   // Storage is deliberately left out of reset; only accepted pushes write it.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= bus.buf_in;
      end
   end

   // Pointers and occupancy count; flush clears them ahead of any transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (bus.flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered read data holds through flush and rejected pops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dout <= '0;
      end else if (w_pop) begin
         r_dout <= r_mem[r_rptr];
      end
   end

   // Sticky error flags, cleared only by reset or flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (bus.flush) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_ovf_evt) r_ovf <= 1'b1;
         if (w_unf_evt) r_unf <= 1'b1;
      end
   end

   // Status flags decode straight from the count register.
   always_comb begin
      bus.buf_out      = r_dout;
      bus.fifo_counter = r_count;
      bus.buf_empty    = w_empty;
      bus.buf_full     = w_full;
      bus.almost_empty = (r_count <= AEMPTY_C);
      bus.almost_full  = (r_count >= AFULL_C);
      bus.overflow     = r_ovf;
      bus.underflow    = r_unf;
   end
endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for fifo_param
module tb_fifo_param;
   logic clk;
   logic rst;
   int   vecs;
   int   errs;

   fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

   fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LVL(14), .AEMPTY_LVL(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock with the given controls, returning 1 time unit after the edge.
   task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic f);
      bus.wr_en  = w;
      bus.rd_en  = r;
      bus.buf_in = d;
      bus.flush  = f;
      @(posedge clk);
      #1;
      bus.wr_en  = 1'b0;
      bus.rd_en  = 1'b0;
      bus.flush  = 1'b0;
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      rst = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.flush = 1'b0;
      bus.buf_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out",   bus.buf_out, 0);
      chk("rst_cnt",   bus.fifo_counter, 0);
      chk("rst_empty", bus.buf_empty, 1);
      chk("rst_full",  bus.buf_full, 0);
      chk("rst_ae",    bus.almost_empty, 1);
      chk("rst_af",    bus.almost_full, 0);
      chk("rst_ovf",   bus.overflow, 0);
      chk("rst_unf",   bus.underflow, 0);
      @(negedge clk);
      rst = 1'b1;

      // fill 1..16
      for (int i = 1; i <= 16; i++) begin
         cyc(1, 0, 8'(i), 0);
         chk($sformatf("fill%0d_cnt", i),  bus.fifo_counter, i);
         chk($sformatf("fill%0d_af", i),   bus.almost_full, (i >= 14) ? 1 : 0);
         chk($sformatf("fill%0d_full", i), bus.buf_full, (i == 16) ? 1 : 0);
         chk($sformatf("fill%0d_ae", i),   bus.almost_empty, (i <= 2) ? 1 : 0);
      end
      cyc(1, 0, 8'd17, 0);
      chk("ovf_set", bus.overflow, 1);
      chk("ovf_cnt", bus.fifo_counter, 16);

      // drain 1..16
      for (int i = 1; i <= 16; i++) begin
         cyc(0, 1, 0, 0);
         chk($sformatf("drain%0d_out", i),   bus.buf_out, i);
         chk($sformatf("drain%0d_cnt", i),   bus.fifo_counter, 16 - i);
         chk($sformatf("drain%0d_ae", i),    bus.almost_empty, (16 - i <= 2) ? 1 : 0);
         chk($sformatf("drain%0d_empty", i), bus.buf_empty, (i == 16) ? 1 : 0);
      end
      cyc(0, 1, 0, 0);
      chk("unf_set",  bus.underflow, 1);
      chk("unf_hold", bus.buf_out, 16);
      chk("unf_ovf_sticky", bus.overflow, 1);

      cyc(0, 0, 0, 1);
      chk("fl1_cnt", bus.fifo_counter, 0);
      chk("fl1_ovf", bus.overflow, 0);
      chk("fl1_unf", bus.underflow, 0);
      chk("fl1_out", bus.buf_out, 16);

      // count 1, push+pop
      cyc(1, 0, 8'd1, 0);
      cyc(1, 1, 8'd2, 0);
      chk("pp1_out", bus.buf_out, 1);
      chk("pp1_cnt", bus.fifo_counter, 1);
      cyc(0, 1, 0, 0);
      chk("pp1_out2",  bus.buf_out, 2);
      chk("pp1_empty", bus.buf_empty, 1);

      // full push+pop with wrapped pointers
      for (int i = 1; i <= 16; i++) cyc(1, 0, 8'(i), 0);
      chk("full2", bus.buf_full, 1);
      cyc(1, 1, 8'd99, 0);
      chk("fpp_out", bus.buf_out, 1);
      chk("fpp_cnt", bus.fifo_counter, 16);
      chk("fpp_ovf", bus.overflow, 0);
      for (int i = 2; i <= 16; i++) begin
         cyc(0, 1, 0, 0);
         chk($sformatf("wrap%0d_out", i), bus.buf_out, i);
      end
      cyc(0, 1, 0, 0);
      chk("wrap_99",    bus.buf_out, 99);
      chk("wrap_empty", bus.buf_empty, 1);

      // empty push+pop
      cyc(1, 1, 8'd5, 0);
      chk("epp_unf", bus.underflow, 1);
      chk("epp_cnt", bus.fifo_counter, 1);
      chk("epp_out", bus.buf_out, 99);
      cyc(0, 1, 0, 0);
      chk("epp_out2", bus.buf_out, 5);

      // count 7 with overflow set, then flush with concurrent requests
      for (int i = 10; i <= 25; i++) cyc(1, 0, 8'(i), 0);
      cyc(1, 0, 8'd26, 0);
      for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0);
      chk("m7_cnt", bus.fifo_counter, 7);
      chk("m7_ovf", bus.overflow, 1);
      chk("m7_out", bus.buf_out, 18);
      cyc(1, 1, 8'd77, 1);
      chk("fl2_cnt",   bus.fifo_counter, 0);
      chk("fl2_empty", bus.buf_empty, 1);
      chk("fl2_ovf",   bus.overflow, 0);
      chk("fl2_unf",   bus.underflow, 0);
      chk("fl2_out",   bus.buf_out, 18);

      // asynchronous reset between edges
      cyc(0, 1, 0, 0);
      for (int i = 30; i <= 36; i++) cyc(1, 0, 8'(i), 0);
      cyc(0, 1, 0, 0);
      chk("pre_rst_out", bus.buf_out, 30);
      chk("pre_rst_cnt", bus.fifo_counter, 6);
      chk("pre_rst_unf", bus.underflow, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out",   bus.buf_out, 0);
      chk("arst_cnt",   bus.fifo_counter, 0);
      chk("arst_empty", bus.buf_empty, 1);
      chk("arst_ae",    bus.almost_empty, 1);
      chk("arst_unf",   bus.underflow, 0);
      @(negedge clk);
      rst = 1'b1;
      cyc(1, 0, 8'd40, 0);
      cyc(0, 1, 0, 0);
      chk("post_rst_out",   bus.buf_out, 40);
      chk("post_rst_empty", bus.buf_empty, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
